// File: rtl/bcp_pkg.sv
// bcp_pkg: shared op-codes, status codes, sequencer state and literal type
// for the BCP command sequencer. Rev 1.0
`default_nettype none

package bcp_pkg;

  localparam logic [1:0] OP_NOP       = 2'b00;
  localparam logic [1:0] OP_UPDATE    = 2'b01;
  localparam logic [1:0] OP_DECIDE    = 2'b10;
  localparam logic [1:0] OP_BACKTRACK = 2'b11;

  localparam logic [2:0] ST_DONE     = 3'd1;
  localparam logic [2:0] ST_CONFLICT = 3'd4;
  localparam logic [2:0] ST_SAT      = 3'd5;
  localparam logic [2:0] ST_IMPL     = 3'd6;
  localparam logic [2:0] ST_TIMEOUT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_STATUS = 2'd2
  } seq_state_e;

  // Literal id width for the default 20-variable formula.
  localparam int LIT_ID_W = 5;

  typedef struct packed {
    logic [LIT_ID_W-1:0] id;
    logic                polarity;
  } lit_t;

  // Status codes that end the command currently in flight.
  function automatic logic is_terminal(input logic [2:0] code);
    return (code == ST_DONE) || (code == ST_CONFLICT) || (code == ST_SAT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcp_sync_fifo.sv
// bcp_sync_fifo: synchronous FIFO with registered storage, no write-to-read
// bypass; push into a full FIFO is accepted only when a pop frees a slot. Rev 1.0
`default_nettype none

module bcp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcp_op_sequencer.sv
// bcp_op_sequencer: buffers PS commands, issues them to the BCP core and
// queues core status events as responses. Optional watchdog: BCP_SEQ_TIMEOUT_EN. Rev 1.0
`default_nettype none

module bcp_op_sequencer
  import bcp_pkg::*;
#(
  parameter int FORMULA_MAX_VARIABLE = 20,
  parameter int MAX_CLAUSE           = 91,
  parameter int CMD_DEPTH            = 4,
  parameter int RSP_DEPTH            = 32,
`ifdef BCP_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES       = 1024,
`endif
  localparam int VAR_LEN = $clog2(FORMULA_MAX_VARIABLE + 1),
  localparam int CID_LEN = $clog2(MAX_CLAUSE),
  localparam int LIT_W   = VAR_LEN + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [CID_LEN-1:0] cmd_cid_i,
  input  logic [3*LIT_W-1:0] cmd_lit_i,
  output logic [1:0]         core_op_o,
  output logic [CID_LEN-1:0] core_cid_o,
  output logic [3*LIT_W-1:0] core_lit_o,
  input  logic               core_clear_req_i,
  input  logic               core_status_valid_i,
  input  logic [2:0]         core_status_i,
  input  logic [LIT_W-1:0]   core_impl_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [2:0]         rsp_code_o,
  output logic [LIT_W-1:0]   rsp_impl_o,
  output logic               busy_o,
  output logic               rsp_overflow_o,
  output logic [15:0]        impl_count_o
);

  localparam int CMD_W = 2 + CID_LEN + 3 * LIT_W;
  localparam int RSP_W = 3 + LIT_W;

  seq_state_e       state;
  seq_state_e       state_nx;
  logic [1:0]       held_op;
  logic             cmd_push;
  logic             cmd_pop;
  logic             cmd_full;
  logic             cmd_empty;
  logic [CMD_W-1:0] cmd_rdata;
  logic             rsp_push;
  logic             rsp_pop;
  logic             rsp_full;
  logic             rsp_empty;
  logic [RSP_W-1:0] rsp_wdata;
  logic [RSP_W-1:0] rsp_rdata;
  logic             have_event;
  logic [RSP_W-1:0] last_event;
  logic             status_event;

  // NOP commands are acknowledged but never stored.
  assign cmd_push    = cmd_valid_i && !cmd_full && (cmd_op_i != OP_NOP);
  assign cmd_ready_o = !cmd_full;

  bcp_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (cmd_push),
    .wdata  ({cmd_op_i, cmd_cid_i, cmd_lit_i}),
    .pop    (cmd_pop),
    .rdata  (cmd_rdata),
    .full   (cmd_full),
    .empty  (cmd_empty)
  );

  assign rsp_valid_o = !rsp_empty;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign rsp_code_o  = rsp_rdata[RSP_W-1 -: 3];
  assign rsp_impl_o  = rsp_rdata[LIT_W-1:0];

  bcp_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (rsp_push),
    .wdata  (rsp_wdata),
    .pop    (rsp_pop),
    .rdata  (rsp_rdata),
    .full   (rsp_full),
    .empty  (rsp_empty)
  );

  // A held status level is taken once; only a changed record is a new event.
  assign status_event = (state == WAIT_STATUS) && core_status_valid_i &&
                        (!have_event || ({core_status_i, core_impl_i} != last_event));

  assign core_op_o = (state == ISSUE) ? held_op : OP_NOP;
  assign busy_o    = (state != IDLE);

`ifdef BCP_SEQ_TIMEOUT_EN
  logic [15:0] wd_count;
  logic        wd_expire;

  assign wd_expire = ((state == ISSUE) || ((state == WAIT_STATUS) && !status_event)) &&
                     (wd_count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     wd_count <= '0;
    else if (cmd_pop || status_event) wd_count <= '0;
    else if (state != IDLE)          wd_count <= wd_count + 16'd1;
  end
`endif

  always_comb begin
    state_nx  = state;
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    rsp_wdata = '0;
    case (state)
      IDLE: begin
        if (!cmd_empty && !core_clear_req_i) begin
          cmd_pop  = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (core_clear_req_i) state_nx = WAIT_STATUS;
      end
      WAIT_STATUS: begin
        if (status_event) begin
          if (core_status_i == ST_IMPL) begin
            rsp_push  = 1'b1;
            rsp_wdata = {ST_IMPL, core_impl_i};
          end else if (is_terminal(core_status_i)) begin
            rsp_push  = 1'b1;
            rsp_wdata = {core_status_i, {LIT_W{1'b0}}};
            state_nx  = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef BCP_SEQ_TIMEOUT_EN
    if (wd_expire) begin
      rsp_push  = 1'b1;
      rsp_wdata = {ST_TIMEOUT, {LIT_W{1'b0}}};
      state_nx  = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      held_op        <= OP_NOP;
      core_cid_o     <= '0;
      core_lit_o     <= '0;
      have_event     <= 1'b0;
      last_event     <= '0;
      impl_count_o   <= '0;
      rsp_overflow_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (cmd_pop) begin
        {held_op, core_cid_o, core_lit_o} <= cmd_rdata;
        have_event <= 1'b0;
      end
      if (status_event) begin
        have_event <= 1'b1;
        last_event <= {core_status_i, core_impl_i};
        if ((core_status_i == ST_IMPL) && (impl_count_o != 16'hFFFF))
          impl_count_o <= impl_count_o + 16'd1;
      end
      // The core is never stalled, so a record that finds no room is lost.
      if (rsp_push && rsp_full && !rsp_pop) rsp_overflow_o <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcp_op_sequencer.sv
// tb_bcp_op_sequencer: directed self-checking bench for bcp_op_sequencer.
// Watchdog scenario follows BCP_SEQ_TIMEOUT_EN. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_bcp_op_sequencer;
  import bcp_pkg::*;

  localparam int TB_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_cid;
  logic [17:0] cmd_lit;
  logic [1:0]  core_op;
  logic [6:0]  core_cid;
  logic [17:0] core_lit;
  logic        core_clear_req;
  logic        core_status_valid;
  logic [2:0]  core_status;
  logic [5:0]  core_impl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_code;
  logic [5:0]  rsp_impl;
  logic        busy;
  logic        rsp_overflow;
  logic [15:0] impl_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcp_op_sequencer #(
    .FORMULA_MAX_VARIABLE (20),
    .MAX_CLAUSE           (91),
    .CMD_DEPTH            (4),
`ifdef BCP_SEQ_TIMEOUT_EN
    .TIMEOUT_CYCLES       (TB_TIMEOUT),
`endif
    .RSP_DEPTH            (32)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cmd_valid_i         (cmd_valid),
    .cmd_ready_o         (cmd_ready),
    .cmd_op_i            (cmd_op),
    .cmd_cid_i           (cmd_cid),
    .cmd_lit_i           (cmd_lit),
    .core_op_o           (core_op),
    .core_cid_o          (core_cid),
    .core_lit_o          (core_lit),
    .core_clear_req_i    (core_clear_req),
    .core_status_valid_i (core_status_valid),
    .core_status_i       (core_status),
    .core_impl_i         (core_impl),
    .rsp_valid_o         (rsp_valid),
    .rsp_ready_i         (rsp_ready),
    .rsp_code_o          (rsp_code),
    .rsp_impl_o          (rsp_impl),
    .busy_o              (busy),
    .rsp_overflow_o      (rsp_overflow),
    .impl_count_o        (impl_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] cid, input logic [17:0] lit);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cid   = cid;
    cmd_lit   = lit;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic ack();
    core_clear_req = 1'b1;
    step();
    core_clear_req = 1'b0;
  endtask

  task automatic status(input logic [2:0] code, input logic [5:0] impl, input int n = 1);
    core_status_valid = 1'b1;
    core_status       = code;
    core_impl         = impl;
    step(n);
  endtask

  task automatic drain(input string tag, input logic [2:0] code, input logic [5:0] impl);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_code"}, rsp_code, code);
    check({tag, "_impl"}, rsp_impl, impl);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    lit_t l0, l1, l2;
    logic [17:0] lits;
    int n;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_cid = '0; cmd_lit = '0;
    core_clear_req = 1'b0; core_status_valid = 1'b0; core_status = '0; core_impl = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_op", core_op, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ovf", rsp_overflow, 0);
    check("rst_impl_cnt", impl_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cid", core_cid, 0);
    check("rst_lit", core_lit, 0);
    rst_n = 1'b1;
    step();

    // Clause update: cid 5, literals {3,1},{7,0},{12,1}
    l0 = '{id: 5'd3, polarity: 1'b1};
    l1 = '{id: 5'd7, polarity: 1'b0};
    l2 = '{id: 5'd12, polarity: 1'b1};
    lits = {l2, l1, l0};
    send(OP_UPDATE, 7'd5, lits);
    check("upd_op_lat1", core_op, 0);
    step();
    check("upd_op_lat2", core_op, 1);
    check("upd_busy", busy, 1);
    check("upd_cid", core_cid, 5);
    check("upd_lit", core_lit, 18'b01100_1_00111_0_00011_1);
    step();
    check("upd_op_hold", core_op, 1);
    ack();
    check("upd_op_cleared", core_op, 0);
    status(ST_DONE, 6'd0);
    core_status_valid = 1'b0;
    check("upd_idle", busy, 0);
    drain("upd_rsp", 3'd1, 6'd0);
    check("upd_rsp_empty", rsp_valid, 0);

    // Decision with two implications, status_valid held high throughout
    send(OP_DECIDE, 7'd0, {12'd0, 5'd4, 1'b1});
    step();
    check("dec_op", core_op, 2);
    ack();
    status(ST_IMPL, {5'd9, 1'b0}, 3);
    status(ST_IMPL, {5'd2, 1'b1}, 2);
    status(ST_DONE, 6'd0, 2);
    core_status_valid = 1'b0;
    check("dec_impl_cnt", impl_count, 2);
    check("dec_idle", busy, 0);
    drain("dec_rsp0", 3'd6, {5'd9, 1'b0});
    drain("dec_rsp1", 3'd6, {5'd2, 1'b1});
    drain("dec_rsp2", 3'd1, 6'd0);
    check("dec_rsp_empty", rsp_valid, 0);

    // Conflict, then a queued backtrack held off while clear_req stays high
    cmd_valid = 1'b1; cmd_op = OP_DECIDE; cmd_cid = '0; cmd_lit = {12'd0, 5'd5, 1'b0};
    step();
    cmd_op = OP_BACKTRACK; cmd_lit = '0;
    step();
    cmd_valid = 1'b0;
    check("cfl_op", core_op, 2);
    core_clear_req = 1'b1;
    step();
    status(ST_CONFLICT, 6'd0);
    core_status_valid = 1'b0;
    step(3);
    check("bt_blocked_op", core_op, 0);
    check("bt_blocked_busy", busy, 0);
    core_clear_req = 1'b0;
    step();
    check("bt_op", core_op, 3);
    ack();
    status(ST_DONE, 6'd0);
    core_status_valid = 1'b0;
    drain("cfl_rsp", 3'd4, 6'd0);
    drain("bt_rsp", 3'd1, 6'd0);

    // Command back-pressure: one in flight plus four buffered
    cmd_valid = 1'b1; cmd_op = OP_UPDATE; cmd_lit = 18'h2A5C3;
    for (int i = 0; i < 6; i++) begin
      cmd_cid = 7'(10 + i);
      step();
      check($sformatf("bp_ready_%0d", i), cmd_ready, (i < 4) ? 1 : 0);
    end
    cmd_valid = 1'b0;
    check("bp_cid", core_cid, 10);

    // Response overflow: 33 distinct implications into a 32-entry FIFO
    ack();
    for (int i = 1; i <= 33; i++) begin
      status(ST_IMPL, 6'(i));
      if (i == 32) check("ovf_before", rsp_overflow, 0);
    end
    check("ovf_after", rsp_overflow, 1);
    status(ST_DONE, 6'd0);
    core_status_valid = 1'b0;
    check("ovf_impl_cnt", impl_count, 35);
    drain("ovf_rsp0", 3'd6, 6'd1);
    drain("ovf_rsp1", 3'd6, 6'd2);
    drain("ovf_rsp2", 3'd6, 6'd3);
    rsp_ready = 1'b1;
    step(29);
    rsp_ready = 1'b0;
    check("ovf_drained", rsp_valid, 0);
    check("bp_order_cid", core_cid, 11);
    check("bp_order_op", core_op, 1);

    // Asynchronous reset in WAIT_STATUS with work queued
    ack();
    status(ST_IMPL, 6'd5);
    core_status_valid = 1'b0;
    check("prerst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_op", core_op, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_ovf", rsp_overflow, 0);
    check("arst_impl_cnt", impl_count, 0);
    check("arst_cid", core_cid, 0);
    check("arst_lit", core_lit, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    #1 rst_n = 1'b1;
    step();
    send(OP_UPDATE, 7'd20, 18'h00F0F);
    step();
    check("post_rst_op", core_op, 1);
    check("post_rst_cid", core_cid, 20);
    ack();
    status(ST_DONE, 6'd0);
    core_status_valid = 1'b0;
    step(2);
    check("post_rst_flushed", busy, 0);
    drain("post_rst_rsp", 3'd1, 6'd0);

    // Core never acknowledges
    send(OP_DECIDE, 7'd0, {12'd0, 5'd1, 1'b1});
    step();
    n = 0;
    while (core_op != 2'b00 && n < 200) begin
      n++;
      step();
    end
`ifdef BCP_SEQ_TIMEOUT_EN
    check("to_issue_cycles", n, TB_TIMEOUT);
    check("to_busy", busy, 0);
    drain("to_rsp", 3'd7, 6'd0);
`else
    check("noto_issue_cycles", n, 200);
    check("noto_busy", busy, 1);
    check("noto_no_rsp", rsp_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
